// File: rtl/rx_256_collect_pkg.sv
// Shared definitions for the receive collector and the transmit-side sequencer:
// one-hot FSM encodings and the default frame length.
package rx_256_collect_pkg;

    localparam int FRAME_LEN_DEF = 256;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_COLLECT = 4'b0010,
        ST_DRAIN   = 4'b0100,
        ST_DONE    = 4'b1000
    } state_t;

endpackage

// File: rtl/rx_256_collect_if.sv
// Bundle of UART-receive, FIFO, drain-handshake and status signals around rx_256_collect.
// slave = collector side, master = surrounding system / bench side.
interface rx_256_collect_if;

    logic       uart_done;
    logic [7:0] uart_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       fifo_rd_en;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       collect_done;
    logic       rx_drop;
    logic       restart;
    logic [3:0] state;

    modport slave (
        input  uart_done, uart_dout, fifo_full, fifo_empty, fifo_dout, rd_ready, restart,
        output fifo_wr_en, fifo_wr_data, fifo_rd_en, rd_valid, rd_data, collect_done,
               rx_drop, state
    );

    modport master (
        output uart_done, uart_dout, fifo_full, fifo_empty, fifo_dout, rd_ready, restart,
        input  fifo_wr_en, fifo_wr_data, fifo_rd_en, rd_valid, rd_data, collect_done,
               rx_drop, state
    );

endinterface

// File: rtl/rx_256_collect_pattern_chk.sv
// rx_pattern_chk: counts drained bytes that differ from their frame index (mod 256).
// Error count saturates at 511 and clears on reset or restart.
module rx_pattern_chk (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       vld_i,
    input  logic [7:0] data_i,
    output logic [8:0] err_cnt_o
);

    logic [7:0] idx_q;
    logic [8:0] err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= 8'd0;
            err_q <= 9'd0;
        end else if (clr_i) begin
            idx_q <= 8'd0;
            err_q <= 9'd0;
        end else if (vld_i) begin
            idx_q <= idx_q + 8'd1;
            if ((data_i != idx_q) && (err_q != 9'd511)) begin
                err_q <= err_q + 9'd1;
            end
        end
    end

    assign err_cnt_o = err_q;

endmodule

// File: rtl/rx_256_collect.sv
// Collects FRAME_LEN received UART bytes into an external FIFO, then drains them to a debug port.
// Optional macro RX_CHECK_EN adds err_cnt, a count of drained bytes that break the 0,1,2.. pattern.
module rx_256_collect
    import rx_256_collect_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    rx_256_collect_if.slave   bus
`ifdef RX_CHECK_EN
    ,
    output logic [8:0]        err_cnt
`endif
);

    localparam logic [8:0] LEN9 = 9'(FRAME_LEN);

    state_t     state_q;
    logic [8:0] wr_cnt_q;
    logic [8:0] rd_cnt_q;
    logic       fifo_wr_en_q;
    logic [7:0] fifo_wr_data_q;
    logic       rd_valid_q;
    logic       rx_drop_q;
    logic       rd_go;
    logic       restart_take;
    logic [7:0] rd_data_w;

    // Read issue is decided in the same cycle as rd_ready so back-to-back reads need no bubble.
    assign rd_go = (state_q == ST_DRAIN) && bus.rd_ready && !bus.fifo_empty && (rd_cnt_q < LEN9);
    assign restart_take = (state_q == ST_DONE) && bus.restart;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= ST_IDLE;
            wr_cnt_q       <= 9'd0;
            rd_cnt_q       <= 9'd0;
            fifo_wr_en_q   <= 1'b0;
            fifo_wr_data_q <= 8'd0;
            rd_valid_q     <= 1'b0;
            rx_drop_q      <= 1'b0;
        end else begin
            fifo_wr_en_q <= 1'b0;
            rd_valid_q   <= rd_go;
            if (rd_go) begin
                rd_cnt_q <= rd_cnt_q + 9'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.uart_done) rx_drop_q <= 1'b1;
                    if (bus.fifo_empty) state_q <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (bus.uart_done) begin
                        if (!bus.fifo_full && (wr_cnt_q < LEN9)) begin
                            fifo_wr_en_q   <= 1'b1;
                            fifo_wr_data_q <= bus.uart_dout;
                            wr_cnt_q       <= wr_cnt_q + 9'd1;
                        end else begin
                            rx_drop_q <= 1'b1;
                        end
                    end
                    // wr_cnt reaches FRAME_LEN together with the final strobe; leave one cycle later.
                    if (wr_cnt_q == LEN9) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (bus.uart_done) rx_drop_q <= 1'b1;
                    if (rd_cnt_q == LEN9) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (restart_take) begin
                        state_q   <= ST_IDLE;
                        wr_cnt_q  <= 9'd0;
                        rd_cnt_q  <= 9'd0;
                        rx_drop_q <= 1'b0;
                    end else if (bus.uart_done) begin
                        rx_drop_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // FIFO read data arrives one cycle after the strobe, aligned with rd_valid_q.
    assign rd_data_w = rd_valid_q ? bus.fifo_dout : 8'd0;

    assign bus.fifo_wr_en   = fifo_wr_en_q;
    assign bus.fifo_wr_data = fifo_wr_data_q;
    assign bus.fifo_rd_en   = rd_go;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_data_w;
    assign bus.collect_done = (state_q == ST_DONE);
    assign bus.rx_drop      = rx_drop_q;
    assign bus.state        = state_q;

`ifdef RX_CHECK_EN
    rx_pattern_chk u_chk (
        .clk_i     (sys_clk),
        .rst_ni    (sys_rst_n),
        .clr_i     (restart_take),
        .vld_i     (rd_valid_q),
        .data_i    (rd_data_w),
        .err_cnt_o (err_cnt)
    );
`endif

endmodule

// File: tb/tb_rx_256_collect.sv
// Directed bench for rx_256_collect with a FIFO model and write/read scoreboards.
// Build with RX_CHECK_EN defined to also exercise err_cnt.
module tb_rx_256_collect;

    logic sys_clk;
    logic sys_rst_n;
    rx_256_collect_if bus ();
`ifdef RX_CHECK_EN
    logic [8:0] err_cnt;
`endif

    rx_256_collect #(.FRAME_LEN(256)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
`ifdef RX_CHECK_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    logic [7:0] wr_exp[$];
    logic [7:0] rd_exp[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // FIFO model: strobes sampled mid-cycle, acted on at the next rising edge.
    logic [7:0] mem[$];
    int   fcnt = 0;
    bit   force_empty = 1'b0;
    bit   force_full  = 1'b0;
    bit   do_wr = 1'b0, do_rd = 1'b0;
    logic [7:0] wdat = 8'd0;
    bit   rdy_toggle = 1'b0;

    assign bus.fifo_empty = (fcnt == 0) || force_empty;
    assign bus.fifo_full  = force_full;

    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            mem.delete();
        end else begin
            if (do_rd && (mem.size() > 0)) bus.fifo_dout <= mem.pop_front();
            if (do_wr) mem.push_back(wdat);
        end
        fcnt <= mem.size();
    end

    always @(posedge sys_clk) begin
        #1;
        bus.rd_ready = rdy_toggle ? ~bus.rd_ready : 1'b1;
    end

    always @(negedge sys_clk) begin
        do_wr = bus.fifo_wr_en;
        do_rd = bus.fifo_rd_en;
        wdat  = bus.fifo_wr_data;
        if (sys_rst_n) begin
            if (bus.fifo_wr_en) begin
                wr_seen++;
                check("wr_expected", 32'(wr_exp.size() > 0), 32'd1);
                if (wr_exp.size() > 0) check("wr_data", bus.fifo_wr_data, wr_exp.pop_front());
            end
            if (bus.rd_valid) begin
                rd_seen++;
                check("rd_expected", 32'(rd_exp.size() > 0), 32'd1);
                if (rd_exp.size() > 0) check("rd_data", bus.rd_data, rd_exp.pop_front());
            end
            if (bus.fifo_rd_en) begin
                check("rd_en_ready", bus.rd_ready, 32'd1);
                check("rd_en_nonempty", bus.fifo_empty, 32'd0);
            end
        end
    end

    // Called and returns at rising edge + 1.
    task automatic send(input logic [7:0] b, input bit acc, input int gap);
        bus.uart_dout = b;
        bus.uart_done = 1'b1;
        if (acc) begin
            wr_exp.push_back(b);
            rd_exp.push_back(b);
        end
        @(posedge sys_clk); #1;
        bus.uart_done = 1'b0;
        repeat (gap) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while ((bus.collect_done !== 1'b1) && (cyc < 5000)) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        check(tag, bus.collect_done, 32'd1);
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(posedge sys_clk); #1;
        bus.restart = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wbase, rbase, k;
        sys_rst_n     = 1'b1;
        bus.uart_done = 1'b0;
        bus.uart_dout = 8'd0;
        bus.restart   = 1'b0;
        bus.fifo_dout = 8'd0;
        #3 sys_rst_n = 1'b0;
        #1;
        check("rst_state", bus.state, 32'h1);
        check("rst_wr_en", bus.fifo_wr_en, 32'd0);
        check("rst_rd_en", bus.fifo_rd_en, 32'd0);
        check("rst_wr_data", bus.fifo_wr_data, 32'd0);
        check("rst_rd_valid", bus.rd_valid, 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        check("rst_done", bus.collect_done, 32'd0);
        check("rst_drop", bus.rx_drop, 32'd0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        check("idle_to_collect", bus.state, 32'h2);

        // Frame 1: 0x00..0xFF, 10-cycle gaps, rd_ready held high.
        wbase = wr_seen; rbase = rd_seen;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) check("f1_no_early_drain", bus.state, 32'h2);
            send(8'(i), 1'b1, 10);
        end
        check("f1_drain", bus.state, 32'h4);
        wait_done("f1_done");
        check("f1_state_done", bus.state, 32'h8);
        check("f1_wr_count", 32'(wr_seen - wbase), 32'd256);
        check("f1_rd_count", 32'(rd_seen - rbase), 32'd256);
        check("f1_drop", bus.rx_drop, 32'd0);
`ifdef RX_CHECK_EN
        check("f1_err_cnt", err_cnt, 32'd0);
`endif
        send(8'h55, 1'b0, 1);
        check("done_discard_drop", bus.rx_drop, 32'd1);
        check("done_hold", bus.state, 32'h8);
        pulse_restart();
        check("restart_idle", bus.state, 32'h1);
        check("restart_clr_drop", bus.rx_drop, 32'd0);
        @(posedge sys_clk); #1;

        // Frame 2: full FIFO at the 100th pulse, rd_ready toggling, drain stall.
        rdy_toggle = 1'b1;
        wbase = wr_seen; rbase = rd_seen; k = 0;
        for (int j = 0; j < 257; j++) begin
            if (j == 10) begin
                pulse_restart();
                check("restart_ignored", bus.state, 32'h2);
            end
            if (j == 256) check("f2_no_early_drain", bus.state, 32'h2);
            if (j == 99) begin
                force_full = 1'b1;
                send(8'hEE, 1'b0, 3);
                force_full = 1'b0;
                check("f2_full_drop", bus.rx_drop, 32'd1);
            end else begin
                send(8'(k), 1'b1, 3);
                k++;
            end
        end
        check("f2_drain", bus.state, 32'h4);
        force_empty = 1'b1;
        repeat (2) @(posedge sys_clk); #1;
        rbase = rd_seen;
        repeat (20) @(posedge sys_clk); #1;
        check("stall_no_read", 32'(rd_seen - rbase), 32'd0);
        check("stall_state", bus.state, 32'h4);
        force_empty = 1'b0;
        wait_done("f2_done");
        check("f2_wr_count", 32'(wr_seen - wbase), 32'd256);
        check("f2_drop_sticky", bus.rx_drop, 32'd1);
        check("f2_sb_empty", 32'(rd_exp.size()), 32'd0);
        rdy_toggle = 1'b0;

        // Restart and uart_done together: restart wins and clears rx_drop.
        wbase = wr_seen;
        bus.uart_dout = 8'h77;
        bus.uart_done = 1'b1;
        bus.restart   = 1'b1;
        @(posedge sys_clk); #1;
        bus.uart_done = 1'b0;
        bus.restart   = 1'b0;
        check("clr_wins_state", bus.state, 32'h1);
        check("clr_wins_drop", bus.rx_drop, 32'd0);
        repeat (3) @(posedge sys_clk); #1;
        check("clr_wins_no_write", 32'(wr_seen - wbase), 32'd0);

        // Frame 3: reset after 50 writes, then a clean frame.
        for (int i = 0; i < 50; i++) send(8'(i), 1'b1, 2);
        #2 sys_rst_n = 1'b0;
        #1;
        check("mid_rst_state", bus.state, 32'h1);
        check("mid_rst_wr_en", bus.fifo_wr_en, 32'd0);
        check("mid_rst_wr_data", bus.fifo_wr_data, 32'd0);
        check("mid_rst_rd_valid", bus.rd_valid, 32'd0);
        check("mid_rst_done", bus.collect_done, 32'd0);
        wr_exp.delete();
        rd_exp.delete();
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        check("post_rst_collect", bus.state, 32'h2);
        wbase = wr_seen; rbase = rd_seen;
        for (int i = 0; i < 256; i++) send(8'(i), 1'b1, 1);
        wait_done("f3_done");
        check("f3_wr_count", 32'(wr_seen - wbase), 32'd256);
        check("f3_rd_count", 32'(rd_seen - rbase), 32'd256);
        check("f3_drop", bus.rx_drop, 32'd0);
        pulse_restart();
        @(posedge sys_clk); #1;

`ifdef RX_CHECK_EN
        // Frame 4: one corrupted byte at index 17.
        for (int i = 0; i < 256; i++) send((i == 17) ? 8'hAA : 8'(i), 1'b1, 1);
        wait_done("f4_done");
        check("f4_err_cnt", err_cnt, 32'd1);
        pulse_restart();
        check("f4_err_clr", err_cnt, 32'd0);
        check("f4_state", bus.state, 32'h1);
`endif

        repeat (2) @(posedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_256_collect.md
RX_256_COLLECT -- requirements
Module: rx_256_collect

Interface
REQ-001 Parameter FRAME_LEN, default 256, bytes per frame collected then drained (legal 2..256).
REQ-002 sys_clk  input  1  single clock; all logic on rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 uart_done  input  1  one-cycle pulse from the UART receiver: byte valid.
REQ-005 uart_dout  input  8  received byte, valid while uart_done=1.
REQ-006 fifo_full  input  1  FIFO full flag.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_dout  input  8  FIFO read data, valid one cycle after fifo_rd_en.
REQ-009 fifo_wr_en  output  1  FIFO write strobe.
REQ-010 fifo_wr_data  output  8  FIFO write data.
REQ-011 fifo_rd_en  output  1  FIFO read strobe.
REQ-012 rd_ready  input  1  downstream (debug capture) accepts a byte this cycle.
REQ-013 rd_valid  output  1  one-cycle pulse: rd_data holds a drained byte.
REQ-014 rd_data  output  8  drained byte.
REQ-015 collect_done  output  1  level, high in DONE.
REQ-016 rx_drop  output  1  sticky: a received byte was discarded.
REQ-017 restart  input  1  pulse: leave DONE and begin a new frame.
REQ-018 state  output  4  one-hot FSM state for debug capture.

Function
REQ-019 FSM one-hot: IDLE=0001, COLLECT=0010, DRAIN=0100, DONE=1000.
REQ-020 IDLE -> COLLECT on the first cycle fifo_empty=1; uart_done in IDLE is discarded and sets rx_drop.
REQ-021 COLLECT: uart_done with fifo_full=0 -> next cycle fifo_wr_en=1, fifo_wr_data=captured uart_dout, wr_cnt+1.
REQ-022 COLLECT: uart_done with fifo_full=1 -> no write, wr_cnt unchanged, rx_drop set.
REQ-023 COLLECT -> DRAIN in the cycle after the write making wr_cnt=FRAME_LEN; wr_cnt is 9 bits, never wraps.
REQ-024 DRAIN: fifo_rd_en=1 in any cycle with rd_ready=1, fifo_empty=0, rd_cnt<FRAME_LEN; back-to-back reads allowed; rd_cnt (9 bits) increments per read.
REQ-025 rd_valid=1 and rd_data=fifo_dout exactly one cycle after each fifo_rd_en; rd_ready is not sampled again for an issued read.
REQ-026 DRAIN: uart_done discarded, rx_drop set.
REQ-027 DRAIN -> DONE in the cycle after the final rd_valid (rd_cnt=FRAME_LEN, no read pending).
REQ-028 DONE: collect_done=1, no FIFO strobes; restart -> IDLE clearing wr_cnt, rd_cnt, rx_drop; restart outside DONE ignored.
REQ-029 uart_done and restart in the same DONE cycle: restart taken, byte discarded, rx_drop cleared (clear wins).
REQ-030 fifo_empty asserted unexpectedly in DRAIN with rd_cnt<FRAME_LEN: stall, no read, no timeout.

Reset
REQ-031 Asynchronous assertion of sys_rst_n=0: state=IDLE, fifo_wr_en=0, fifo_rd_en=0, fifo_wr_data=0, rd_valid=0, rd_data=0, collect_done=0, rx_drop=0, counters 0; applies mid-frame, pending read discarded.
REQ-032 Release: first transition evaluated on the first sys_clk edge with sys_rst_n=1.

Configuration
REQ-033 Macro RX_CHECK_EN defined: output err_cnt (9 bits) counts drained bytes with rd_data != (rd_cnt index mod 256), index from 0; clears on reset/restart, saturates at 511.
REQ-034 RX_CHECK_EN undefined: no err_cnt port, no compare logic; all other behaviour identical.

Structure
REQ-035 Shared package holds the four one-hot state constants and the default FRAME_LEN, also used by the transmit-side sequencer.
REQ-036 One sub-module natural: rx_pattern_chk (compare and err_cnt), instantiated only under RX_CHECK_EN.

Verification
REQ-037 256 uart_done pulses, bytes 0x00..0xFF, gaps 10 cycles, rd_ready=1 -> 256 fifo_wr_en, DRAIN, 256 rd_valid with rd_data 0x00..0xFF, collect_done=1, rx_drop=0, err_cnt=0.
REQ-038 fifo_full=1 at the 100th uart_done -> no write for it, rx_drop=1, DRAIN entered only after 256 successful writes.
REQ-039 DRAIN with rd_ready toggling 1/0 each cycle -> fifo_rd_en only when rd_ready=1, 256 rd_valid, order preserved.
REQ-040 sys_rst_n=0 after 50 writes -> all outputs zero within the reset, state=0001; new frame collected cleanly after release.
REQ-041 RX_CHECK_EN, byte 17 sent as 0xAA -> err_cnt=1 in DONE; restart -> err_cnt=0, state=0001.
REQ-042 uart_done and restart same DONE cycle -> state=IDLE, rx_drop=0, no fifo_wr_en.
